lector_salida: RTL and testbench
================================

Name: lector_salida

Overview:
- Egress reader for the PCIE switch: the consumer side of the four output FIFOs written by arbitro1.
- Monitors each FIFO's empty flag, grants one non-empty FIFO round-robin, issues a one-cycle pop, captures the word, and presents it downstream on a valid/ready handshake tagged with the source port.
- Replaces the testbench-side drain logic so the full datapath is closed inside RTL.

Parameters:
- TAMANO_DATOS, 12, word width (class [11:10], dest [9:8], payload [7:0]).
- NUM_PUERTOS, 4, number of output FIFOs drained (fixed at 4; the port-id width is 2).
- CONT_W, 5, width of each per-port read counter (optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- empty  in  4  empty flags of output FIFOs 0..3.
- data_bus  in  48  FIFO data_out words concatenated; FIFO i occupies bits [12*i+11:12*i].
- pop  out  4  one-hot read_enable to FIFOs 0..3.
- out_data  out  12  captured word.
- out_port  out  2  index of the FIFO the word came from.
- out_valid  out  1  out_data/out_port are valid.
- out_ready  in  1  downstream accepts the word.
- count_bus  out  4*CONT_W  per-port words-delivered counters; port i occupies bits [CONT_W*i+CONT_W-1:CONT_W*i].

Behaviour:
- Reset (asynchronous, immediate):
  - pop=0, out_data=0, out_port=0, out_valid=0, count_bus=0.
  - rr_ptr=0, state=IDLE.
  - A word popped but not yet delivered is dropped.
- FIFO timing: a FIFO updates data_out on the clock edge that samples its read_enable. The word is therefore stable during the cycle after pop.
- States (2-bit encoding): IDLE=0, POP=1, CAPTURE=2, HOLD=3.
- IDLE:
  - If empty!=4'hF, select grant g = first non-empty index searching rr_ptr, rr_ptr+1, ... mod 4.
  - Register g and go to POP. Otherwise stay in IDLE.
- POP:
  - pop[g]=1 for exactly this cycle; all other pop bits are 0.
  - rr_ptr <= (g+1) mod 4. Next state is CAPTURE.
- CAPTURE:
  - pop=0. At the end of the cycle: out_data <= data_bus[g slice], out_port <= g, out_valid <= 1.
  - Next state is HOLD.
- HOLD:
  - out_valid=1; out_data and out_port are held stable while out_ready=0.
  - On out_ready=1 the transfer completes at that edge and the count for port g increments.
  - If, in the same cycle, empty!=4'hF: the new grant is computed from the updated rr_ptr and the next state is POP; out_valid drops to 0 next cycle.
  - Otherwise out_valid drops to 0 and the next state is IDLE.
- Latency: pop cycle to first out_valid cycle = 2 clocks. Maximum throughput with out_ready held at 1 is one word per 3 clocks.
- Empty is sampled only in IDLE and in HOLD on completion. Empty flags are never re-checked during POP or CAPTURE.
- pop is never asserted to a FIFO whose empty was 1 at the grant decision, so there is no underflow.
- Counters: CONT_W bits each; they wrap from 2^CONT_W-1 to 0 with no saturation.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro: LECTOR_SALIDA_CONT_EN.
- Defined: four CONT_W-bit counters drive count_bus, incremented on each completed handshake (out_valid & out_ready) for out_port.
- Undefined: no counter flops are built; count_bus is tied to 0. All other behaviour is identical.

Decomposition:
- Shared include (pcie_defs.vh), also used by arbitro1/arbitro2/contadores:
  - TAMANO_DATOS, NUM_PUERTOS.
  - Field positions CLASS_MSB/LSB=11/10, DEST_MSB/LSB=9/8.
  - State encodings for this block.
- One sub-module, selector_rr:
  - Combinational round-robin grant: inputs req[3:0] (=~empty) and rr_ptr[1:0]; outputs grant[1:0] and any_req.
  - lector_salida owns rr_ptr and the FSM.

Test Plan:
- Reset mid-HOLD (out_valid=1, reset pulsed between edges) -> out_valid, pop and count_bus go to 0 immediately, without waiting for a clock edge. The FSM restarts in IDLE with rr_ptr=0.
- Only FIFO 2 non-empty, holding 0xA5C; out_ready=1 -> pop=4'b0100 for 1 cycle. 2 cycles later out_valid=1, out_data=12'hA5C, out_port=2. count for port 2 = 1.
- All four FIFOs non-empty, out_ready=1 -> pops in order 0,1,2,3,0; pop pulses spaced 3 clocks apart; out_port sequence 0,1,2,3,0.
- out_ready=0 for 5 cycles while out_valid=1 -> out_data and out_port stay stable and no further pop occurs. After out_ready=1, exactly one handshake and one count increment.
- empty=4'hF throughout -> pop stays 0 and out_valid stays 0; the FSM remains in IDLE.
- Port 1 fed 33 words with the macro defined -> count for port 1 wraps to 1. With the macro undefined -> count_bus=0 throughout.

Source files
------------

// File: rtl/lector_salida_pkg.sv
// Shared definitions for the egress reader: word layout, port count and FSM states.
package lector_salida_pkg;

    localparam int TAMANO_DATOS = 12;
    localparam int NUM_PUERTOS  = 4;
    localparam int PORT_W       = 2;
    localparam int CONT_W       = 5;

    localparam int CLASS_MSB = 11;
    localparam int CLASS_LSB = 10;
    localparam int DEST_MSB  = 9;
    localparam int DEST_LSB  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        POP     = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } estado_t;

endpackage

// File: rtl/lector_salida_selector_rr.sv
// Combinational round-robin grant over four requesters, starting at rr_ptr.
module selector_rr
    import lector_salida_pkg::*;
(
    input  logic [NUM_PUERTOS-1:0] req,
    input  logic [PORT_W-1:0]      rr_ptr,
    output logic [PORT_W-1:0]      grant,
    output logic                   any_req
);

    logic [PORT_W-1:0] idx;

    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = |req;
        // Walk offsets high to low so the smallest offset from rr_ptr wins.
        for (int k = NUM_PUERTOS - 1; k >= 0; k--) begin
            idx = rr_ptr + PORT_W'(k);
            if (req[idx]) grant = idx;
        end
    end

endmodule

// File: rtl/lector_salida.sv
// Egress reader: drains four output FIFOs round-robin onto a valid/ready port.
// Optional per-port delivery counters: define LECTOR_SALIDA_CONT_EN.
module lector_salida
    import lector_salida_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_PUERTOS-1:0]            empty,
    input  logic [NUM_PUERTOS*TAMANO_DATOS-1:0] data_bus,
    output logic [NUM_PUERTOS-1:0]            pop,
    output logic [TAMANO_DATOS-1:0]           out_data,
    output logic [PORT_W-1:0]                 out_port,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_PUERTOS*CONT_W-1:0]     count_bus
);

    estado_t           state, state_nxt;
    logic [PORT_W-1:0] g, g_nxt;
    logic [PORT_W-1:0] rr_ptr;
    logic [PORT_W-1:0] grant;
    logic              any_req;
    logic [TAMANO_DATOS-1:0] word;

    selector_rr u_sel (
        .req     (~empty),
        .rr_ptr  (rr_ptr),
        .grant   (grant),
        .any_req (any_req)
    );

    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_PUERTOS; i++) begin
            if (g == PORT_W'(i)) word = data_bus[i*TAMANO_DATOS +: TAMANO_DATOS];
        end
    end

    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        pop       = '0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    g_nxt     = grant;
                    state_nxt = POP;
                end
            end
            POP: begin
                pop[g]    = 1'b1;
                state_nxt = CAPTURE;
            end
            CAPTURE: state_nxt = HOLD;
            HOLD: begin
                if (out_ready) begin
                    if (any_req) begin
                        g_nxt     = grant;
                        state_nxt = POP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            g         <= '0;
            rr_ptr    <= '0;
            out_data  <= '0;
            out_port  <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            g     <= g_nxt;
            if (state == POP) rr_ptr <= g + PORT_W'(1);
            // FIFO data_out settled on the pop edge, so it is sampled here.
            if (state == CAPTURE) begin
                out_data  <= word;
                out_port  <= g;
                out_valid <= 1'b1;
            end
            if (state == HOLD && out_ready) out_valid <= 1'b0;
        end
    end

`ifdef LECTOR_SALIDA_CONT_EN
    logic [CONT_W-1:0] cont [NUM_PUERTOS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PUERTOS; i++) cont[i] <= '0;
        end else if (out_valid && out_ready) begin
            cont[out_port] <= cont[out_port] + CONT_W'(1);
        end
    end

    always_comb begin
        count_bus = '0;
        for (int i = 0; i < NUM_PUERTOS; i++) count_bus[i*CONT_W +: CONT_W] = cont[i];
    end
`else
    assign count_bus = '0;
`endif

endmodule

// File: tb/tb_lector_salida.sv
// Directed bench for lector_salida with a behavioural model of the four FIFOs.
module tb_lector_salida;
    import lector_salida_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  empty;
    logic [47:0] data_bus;
    logic [3:0]  pop;
    logic [11:0] out_data;
    logic [1:0]  out_port;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] count_bus;

    always #5 clk = ~clk;

    lector_salida dut (
        .clk       (clk),
        .reset     (reset),
        .empty     (empty),
        .data_bus  (data_bus),
        .pop       (pop),
        .out_data  (out_data),
        .out_port  (out_port),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count_bus (count_bus)
    );

    logic [11:0] mem [4][64];
    int          head [4] = '{0, 0, 0, 0};
    int          tail [4] = '{0, 0, 0, 0};
    logic [11:0] dout [4] = '{12'h0, 12'h0, 12'h0, 12'h0};
    int          underflow = 0;
    int          hs [4] = '{0, 0, 0, 0};
    int          cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (pop[i]) begin
                if (head[i] == tail[i]) begin
                    underflow <= underflow + 1;
                end else begin
                    dout[i] <= mem[i][head[i] % 64];
                    head[i] <= head[i] + 1;
                end
            end
        end
        if (out_valid && out_ready) hs[out_port] <= hs[out_port] + 1;
    end

    always @* begin
        for (int i = 0; i < 4; i++) begin
            empty[i] = (head[i] == tail[i]);
            data_bus[i*12 +: 12] = dout[i];
        end
    end

    int passed = 0;
    int total  = 0;
    int exp_cnt [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input int p, input logic [11:0] w);
        mem[p][tail[p] % 64] = w;
        tail[p] = tail[p] + 1;
    endtask

    function automatic logic [31:0] cnt_exp(input int p);
`ifdef LECTOR_SALIDA_CONT_EN
        return 32'(exp_cnt[p] % 32);
`else
        return 32'(p * 0);
`endif
    endfunction

    function automatic logic [31:0] cnt_of(input int p);
        return 32'(count_bus[p*5 +: 5]);
    endfunction

    typedef struct {
        int          port;
        logic [11:0] word;
        logic [3:0]  exp_pop;
        logic [1:0]  exp_port;
        logic [11:0] exp_data;
    } vec_t;

    vec_t tbl [4];

    logic [3:0]  pops  [8];
    int          pcyc  [8];
    logic [1:0]  oport [8];
    logic [11:0] odata [8];

    initial begin
        int np, no, found, h0, nz;
        logic [3:0]  rr_pop  [5];
        logic [1:0]  rr_port [5];
        logic [11:0] rr_data [5];

        tbl[0] = '{2, 12'hA5C, 4'b0100, 2'd2, 12'hA5C};
        tbl[1] = '{0, 12'h3F1, 4'b0001, 2'd0, 12'h3F1};
        tbl[2] = '{3, 12'hFFF, 4'b1000, 2'd3, 12'hFFF};
        tbl[3] = '{1, 12'h000, 4'b0010, 2'd1, 12'h000};
        rr_pop  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_port = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rr_data = '{12'h100, 12'h211, 12'h322, 12'h433, 12'h144};
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;

        reset     = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("rst_pop", 32'(pop), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_port", 32'(out_port), 0);
        chk("rst_count", 32'(count_bus), 0);
        reset = 1'b0;

        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("idle_pop", 32'(pop), 0);
            chk("idle_valid", 32'(out_valid), 0);
        end

        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            push(tbl[v].port, tbl[v].word);
            found = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (pop != 4'b0) begin
                    found = 1;
                    break;
                end
            end
            chk("tbl_pop_seen", 32'(found), 1);
            chk("tbl_pop", 32'(pop), 32'(tbl[v].exp_pop));
            @(negedge clk);
            chk("tbl_pop_1cyc", 32'(pop), 0);
            chk("tbl_valid_early", 32'(out_valid), 0);
            @(negedge clk);
            chk("tbl_valid", 32'(out_valid), 1);
            chk("tbl_data", 32'(out_data), 32'(tbl[v].exp_data));
            chk("tbl_port", 32'(out_port), 32'(tbl[v].exp_port));
            exp_cnt[tbl[v].port]++;
            @(negedge clk);
            chk("tbl_valid_drop", 32'(out_valid), 0);
            chk("tbl_count", cnt_of(tbl[v].port), cnt_exp(tbl[v].port));
        end

        out_ready = 1'b0;
        push(1, 12'h5A7);
        found = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1;
                break;
            end
        end
        chk("stall_valid_seen", 32'(found), 1);
        push(3, 12'h6B8);
        h0 = hs[1];
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_data", 32'(out_data), 32'h5A7);
            chk("stall_port", 32'(out_port), 1);
            chk("stall_pop", 32'(pop), 0);
        end
        chk("stall_cnt_hold", cnt_of(1), cnt_exp(1));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        exp_cnt[1]++;
        chk("stall_one_hs", 32'(hs[1] - h0), 1);
        chk("stall_count", cnt_of(1), cnt_exp(1));
        chk("stall_valid_drop", 32'(out_valid), 0);
        chk("stall_next_pop", 32'(pop), 32'b1000);
        @(negedge clk);
        @(negedge clk);
        chk("hold2_valid", 32'(out_valid), 1);
        chk("hold2_data", 32'(out_data), 32'h6B8);
        chk("hold2_port", 32'(out_port), 3);

        #1 reset = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_pop", 32'(pop), 0);
        chk("arst_data", 32'(out_data), 0);
        chk("arst_count", 32'(count_bus), 0);
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        @(negedge clk);
        reset = 1'b0;

        push(0, 12'h100);
        push(1, 12'h211);
        push(2, 12'h322);
        push(3, 12'h433);
        push(0, 12'h144);
        out_ready = 1'b1;
        np = 0;
        no = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (pop != 4'b0 && np < 8) begin
                pops[np] = pop;
                pcyc[np] = cyc;
                np++;
            end
            if (out_valid && no < 8) begin
                oport[no] = out_port;
                odata[no] = out_data;
                no++;
            end
        end
        chk("rr_npop", 32'(np), 5);
        chk("rr_nout", 32'(no), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < np) chk("rr_pop", 32'(pops[k]), 32'(rr_pop[k]));
            if (k > 0 && k < np) chk("rr_spacing", 32'(pcyc[k] - pcyc[k-1]), 3);
            if (k < no) begin
                chk("rr_port", 32'(oport[k]), 32'(rr_port[k]));
                chk("rr_data", 32'(odata[k]), 32'(rr_data[k]));
            end
        end
        exp_cnt[0] += 2;
        exp_cnt[1] += 1;
        exp_cnt[2] += 1;
        exp_cnt[3] += 1;
        for (int p = 0; p < 4; p++) chk("rr_count", cnt_of(p), cnt_exp(p));

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        h0 = hs[1];
        nz = 0;
        for (int i = 0; i < 33; i++) push(1, 12'(i + 12'h700));
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (count_bus != 20'h0) nz = 1;
            if (hs[1] - h0 >= 33) break;
        end
        exp_cnt[1] = 33;
        chk("wrap_delivered", 32'(hs[1] - h0), 33);
`ifdef LECTOR_SALIDA_CONT_EN
        chk("wrap_count", cnt_of(1), 1);
`else
        chk("wrap_count", cnt_of(1), 0);
        chk("count_zero", 32'(nz), 0);
`endif
        chk("wrap_count_model", cnt_of(1), cnt_exp(1));
        chk("no_underflow", 32'(underflow), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
